// File: rtl/npuf_pkg.sv
// Shared definitions for the NPUF batch sequencer: FSM state encoding,
// LFSR tap positions, default sizing and small helper functions.
package npuf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } npuf_state_e;

  localparam int NPUF_RESP_W_DEF  = 32;
  localparam int NPUF_RST_CYC_DEF = 4;

  // Fibonacci taps 128/126/101/99 expressed as zero-based bit indices
  localparam int LFSR_W    = 128;
  localparam int LFSR_TAP0 = 127;
  localparam int LFSR_TAP1 = 125;
  localparam int LFSR_TAP2 = 100;
  localparam int LFSR_TAP3 = 98;

  // One shift of the challenge LFSR
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] c);
    logic fb;
    fb = c[LFSR_TAP0] ^ c[LFSR_TAP1] ^ c[LFSR_TAP2] ^ c[LFSR_TAP3];
    return {c[LFSR_W-2:0], fb};
  endfunction

  // An all-zero state would lock the LFSR, so substitute 1
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/npuf_lfsr128.sv
// 128-bit Fibonacci challenge generator. Load has priority over step;
// the state is zero after reset and only changes on load or step.
module npuf_lfsr128
  import npuf_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [127:0] load_val,
  input  logic         step,
  output logic [127:0] state
);

  logic [127:0] state_q, state_d;

  // Next challenge: reload, advance, or hold
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  // Challenge register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/npuf_seq.sv
// NPUF batch sequencer: for each response bit, holds the arbiters in reset,
// lets them settle, samples puf_out and advances the challenge LFSR.
// Optional build macro NPUF_SEQ_MAJORITY_EN: evaluate each bit three times
// on the same challenge and shift in the majority vote.
module npuf_seq
  import npuf_pkg::*;
#(
  parameter int RESP_W  = NPUF_RESP_W_DEF,
  parameter int RST_CYC = NPUF_RST_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  input  logic [1:0]        length,
  input  logic [127:0]      seed,
  input  logic [7:0]        settle,
  output logic              puf_reset,
  output logic [1:0]        puf_length,
  output logic [127:0]      puf_c,
  input  logic              puf_out,
  output logic [RESP_W-1:0] resp,
  output logic              resp_valid,
  input  logic              resp_ready
);

  // Phase counter must cover both the reset hold and a settle of 255
  localparam int CNT_MAX = (RST_CYC > 256) ? RST_CYC : 256;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(RESP_W + 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(RESP_W - 1);

  npuf_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        settle_q, settle_d;
  logic [1:0]        length_q, length_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic              resp_valid_q, resp_valid_d;
  logic              lfsr_load, lfsr_step;
  logic [127:0]      lfsr_state;
  logic [CNT_W-1:0]  settle_last;

`ifdef NPUF_SEQ_MAJORITY_EN
  logic [1:0] ev_q, ev_d;
  logic [1:0] smp_q, smp_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  // A settle of zero still gets one settle cycle
  assign settle_last = (settle_q == 8'd0) ? '0 : CNT_W'(settle_q - 8'd1);

  npuf_lfsr128 u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (lfsr_load),
    .load_val (seed_fix(seed)),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  // Next-state and datapath control for the evaluation sequence
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    settle_d     = settle_q;
    length_d     = length_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
`ifdef NPUF_SEQ_MAJORITY_EN
    ev_d         = ev_q;
    smp_d        = smp_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          length_d  = length;
          settle_d  = settle;
          resp_d    = '0;
          bit_d     = '0;
          cnt_d     = '0;
`ifdef NPUF_SEQ_MAJORITY_EN
          ev_d      = '0;
          smp_d     = '0;
`endif
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        if (cnt_q == ARM_LAST) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == settle_last) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
`ifdef NPUF_SEQ_MAJORITY_EN
        if (ev_q != 2'd2) begin
          // Keep earlier votes, re-evaluate the same challenge
          smp_d[ev_q[0]] = puf_out;
          ev_d           = ev_q + 2'd1;
          state_d        = ST_ARM;
        end else begin
          resp_d    = {resp_q[RESP_W-2:0], maj3(smp_q[0], smp_q[1], puf_out)};
          lfsr_step = 1'b1;
          ev_d      = '0;
          bit_d     = bit_q + BIT_W'(1);
          state_d   = (bit_q == BIT_LAST) ? ST_DONE : ST_ARM;
        end
`else
        resp_d    = {resp_q[RESP_W-2:0], puf_out};
        lfsr_step = 1'b1;
        bit_d     = bit_q + BIT_W'(1);
        state_d   = (bit_q == BIT_LAST) ? ST_DONE : ST_ARM;
`endif
      end
      ST_DONE: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      settle_q     <= '0;
      length_q     <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
`ifdef NPUF_SEQ_MAJORITY_EN
      ev_q         <= '0;
      smp_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      settle_q     <= settle_d;
      length_q     <= length_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
`ifdef NPUF_SEQ_MAJORITY_EN
      ev_q         <= ev_d;
      smp_q        <= smp_d;
`endif
    end
  end

  // Arbiters are released only while settling and sampling
  assign puf_reset  = !((state_q == ST_SETTLE) || (state_q == ST_SAMPLE));
  assign busy       = (state_q != ST_IDLE);
  assign puf_c      = lfsr_state;
  assign puf_length = length_q;
  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_npuf_seq.sv
// Self-checking bench for npuf_seq with a behavioural PUF stub and model.
module tb_npuf_seq;

  localparam int RESP_W  = 32;
  localparam int RST_CYC = 4;
`ifdef NPUF_SEQ_MAJORITY_EN
  localparam int EVALS = 3;
`else
  localparam int EVALS = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic [1:0]        length = 2'd0;
  logic [127:0]      seed = '0;
  logic [7:0]        settle = 8'd0;
  logic              puf_reset;
  logic [1:0]        puf_length;
  logic [127:0]      puf_c;
  logic              puf_out;
  logic [RESP_W-1:0] resp;
  logic              resp_valid;
  logic              resp_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // Stub: mode 0 echoes puf_c[0]; mode 1 plays pat[] per evaluation
  int       mode = 0;
  logic [2:0] pat = 3'b000;
  int       evals = 0;
  int       base = 0;
  logic     pr_prev = 1'b1;
  int       idx;

  npuf_seq #(.RESP_W(RESP_W), .RST_CYC(RST_CYC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .busy       (busy),
    .length     (length),
    .seed       (seed),
    .settle     (settle),
    .puf_reset  (puf_reset),
    .puf_length (puf_length),
    .puf_c      (puf_c),
    .puf_out    (puf_out),
    .resp       (resp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  // Every release of puf_reset starts a new evaluation
  always @(negedge clk) begin
    if (pr_prev && !puf_reset) evals <= evals + 1;
    pr_prev <= puf_reset;
  end

  always_comb begin
    idx = evals - base - 1;
    if (idx < 0) idx = 0;
    idx = idx % 3;
  end

  assign puf_out = (mode == 0) ? puf_c[0] : pat[idx];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] m_step(input logic [127:0] c);
    return {c[126:0], c[127] ^ c[125] ^ c[100] ^ c[98]};
  endfunction

  // Expected response word computed from the challenge sequence
  function automatic logic [RESP_W-1:0] m_resp(input logic [127:0] sd);
    logic [127:0] c;
    logic [RESP_W-1:0] r;
    logic b;
    int ones;
    c = (sd == '0) ? 128'h1 : sd;
    r = '0;
    for (int i = 0; i < RESP_W; i++) begin
      if (mode == 0) begin
        b = c[0];
      end else begin
        ones = int'(pat[0]) + int'(pat[1]) + int'(pat[2]);
        b = (ones >= 2);
      end
      r = {r[RESP_W-2:0], b};
      c = m_step(c);
    end
    return r;
  endfunction

  function automatic int m_lat(input logic [7:0] st);
    int s;
    s = (st == 0) ? 1 : int'(st);
    return RESP_W * EVALS * (RST_CYC + s + 1) + 1;
  endfunction

  task automatic run_batch(input string tag, input logic [127:0] sd, input logic [1:0] ln,
                           input logic [7:0] st, input int stall, input bit pulse);
    logic [RESP_W-1:0] exp_r, held;
    logic [127:0] prev_c;
    logic prev_r;
    int exp_l, lat, viol, unstable;
    exp_r = m_resp(sd);
    exp_l = m_lat(st);
    base = evals;
    seed = sd; length = ln; settle = st; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs wander after acceptance; latched copies must govern
    settle = 8'($urandom); length = 2'($urandom);
    seed = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, "_busy"}, busy, 1'b1);
    lat = 0; viol = 0;
    prev_c = puf_c; prev_r = puf_reset;
    for (int k = 1; k <= exp_l + 20; k++) begin
      @(posedge clk); #1;
      if (puf_c !== prev_c && !(prev_r == 1'b0 && puf_reset == 1'b1)) viol++;
      prev_c = puf_c; prev_r = puf_reset;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      chk({tag, "_timeout"}, 1'b0, 1'b1);
      return;
    end
    chk({tag, "_lat"}, lat, exp_l);
    chk({tag, "_resp"}, resp, exp_r);
    chk({tag, "_len"}, puf_length, ln);
    chk({tag, "_c_stable"}, viol, 0);
    held = resp;
    unstable = 0;
    for (int i = 0; i < stall; i++) begin
      if (pulse && (i == 10 || i == 30)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (resp !== held || resp_valid !== 1'b1 || busy !== 1'b1) unstable++;
    end
    if (stall > 0) chk({tag, "_stall"}, unstable, 0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_vld_drop"}, resp_valid, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_park"}, puf_reset, 1'b1);
  endtask

  initial begin
    logic [127:0] rs;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_pr", puf_reset, 1'b1);
    chk("rst_vld", resp_valid, 1'b0);
    chk("rst_resp", resp, 0);
    chk("rst_c", puf_c, 0);
    chk("rst_len", puf_length, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_pr", puf_reset, 1'b1);

    run_batch("seed1", 128'h1, 2'd1, 8'd16, 50, 1'b1);
    run_batch("seed0", 128'h0, 2'd2, 8'd16, 0, 1'b0);
    run_batch("settle0", {$urandom, $urandom, $urandom, $urandom}, 2'd0, 8'd0, 0, 1'b0);

    // Reset in the middle of bit 10
    seed = {$urandom, $urandom, $urandom, $urandom}; settle = 8'd16; length = 2'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10 * EVALS * (RST_CYC + 16 + 1) + 5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_pr", puf_reset, 1'b1);
    chk("mid_resp", resp, 0);
    chk("mid_c", puf_c, 0);
    chk("mid_len", puf_length, 0);
    run_batch("after_rst", {$urandom, $urandom, $urandom, $urandom}, 2'd1, 8'd16, 0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      run_batch("rand", rs, 2'($urandom), 8'($urandom_range(0, 20)), $urandom_range(0, 5), 1'b0);
    end
    run_batch("settle255", 128'h5a5a_0000_1234_ffff_0000_0001_8000_0003, 2'd2, 8'd255, 0, 1'b0);

`ifdef NPUF_SEQ_MAJORITY_EN
    mode = 1;
    pat = 3'b101;
    run_batch("maj101", {$urandom, $urandom, $urandom, $urandom}, 2'd0, 8'd16, 0, 1'b0);
    pat = 3'b010;
    run_batch("maj010", {$urandom, $urandom, $urandom, $urandom}, 2'd0, 8'd16, 0, 1'b0);
    mode = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
